accum_rd_ctrl: RTL and testbench
================================

Name: accum_rd_ctrl

Overview:
- Read-side controller for the accumulator SRAM banks (one bank per systolic-array column, SYS_COL banks, ACCUM_ROW rows each).
- Accepts a drain command (start row, row count) and issues read enables/addresses to all banks in lockstep.
- Captures the returned rows in a 2-entry buffer and presents them on a valid/ready output stream towards the activation/output path, with full backpressure support.
- Counterpart of the accumulator write-side skew controller.

Parameters:
- SYS_COL, 16, number of accumulator columns/banks.
- ACCUM_ROW, 256, rows per bank; must be a power of two.
- DATA_WIDTH, 32, bits per accumulator entry.
- ADDR_WIDTH, $clog2(ACCUM_ROW) (localparam), row address width.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset.
- cmd_valid  input  1  drain command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  input  ADDR_WIDTH  first row to read.
- cmd_len  input  ADDR_WIDTH+1  rows to read, 0..ACCUM_ROW.
- rd_en_out  output  SYS_COL  per-bank read enable; all bits are always equal.
- rd_addr_out  output  ADDR_WIDTH  row address shared by all banks.
- rd_data_in  input  SYS_COL*DATA_WIDTH  bank read data, valid the cycle after rd_en_out; column i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  output row valid.
- out_ready  input  1  downstream accepts the row.
- out_data  output  SYS_COL*DATA_WIDTH  output row.
- out_last  output  1  marks the final row of the command.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is synchronous, active-low (rstn).
- Reset values (on rstn=0 at a posedge):
  - State = IDLE.
  - Buffer emptied, in-flight flag cleared.
  - rd_en_out=0, rd_addr_out=0, out_valid=0, out_last=0, busy=0.
  - cmd_ready=1 from the first cycle after reset.
- Reset mid-operation: all of the above apply; rd_data_in returning in the following cycle is discarded.
- State machine:
  - IDLE: cmd_ready=1.
    - Handshake with cmd_len=0: command is consumed, no reads, stay IDLE.
    - Handshake with cmd_len>0: latch addr and remaining count = cmd_len; go to ISSUE.
  - ISSUE: cmd_ready=0. Each cycle a read is issued when occ + inflight - pop < 2, where:
    - occ = buffer occupancy (0..2);
    - inflight = read issued in the previous cycle;
    - pop = out_valid && out_ready this cycle.
  - On each issue:
    - rd_en_out = all ones; rd_addr_out = current address.
    - Address increments modulo ACCUM_ROW (ACCUM_ROW-1 wraps to 0).
    - Remaining count decrements.
    - Issuing the last row goes to DRAIN.
  - DRAIN: no reads issued. Go to IDLE in the cycle the last row is popped. cmd_ready rises the next cycle.
- rd_en_out is 0 in every cycle with no issue. rd_addr_out holds its last value when idle.
- Data capture:
  - rd_data_in is sampled in the cycle after an issue and written into the buffer at that cycle's clock edge.
  - The tag last = (that read was the command's final row) is stored with it.
- Output:
  - out_valid = buffer non-empty. out_data and out_last come from the head entry (registered storage).
  - While out_valid && !out_ready, out_data and out_last are held stable.
- Latency and throughput:
  - Command accepted at cycle 0, first read at cycle 1, data at cycle 2, out_valid at cycle 3.
  - With out_ready held high: 1 row/cycle, no bubbles.
- Backpressure:
  - The buffer never overflows. The issue rule guarantees occ + inflight ≤ 2.
  - With out_ready=0, at most 2 rows are outstanding.
- Simultaneous events: a push and a pop in the same cycle leave occ unchanged.
- A cmd_valid pulse while busy is ignored; it stays pending upstream.

Test Plan:
- Basic drain: cmd_addr=5, cmd_len=4, out_ready=1.
  - Reads at addresses 5,6,7,8 on cycles 1–4.
  - out_valid on cycles 3–6; out_data echoes the bank model at rows 5–8.
  - out_last only on row 8; busy falls and cmd_ready rises in cycle 7.
- Wrap-around: cmd_addr=254, cmd_len=4 → read addresses 254,255,0,1; out_last on row 1.
- Backpressure: cmd_addr=0, cmd_len=8, out_ready=0 for cycles 0–10, then 1.
  - Exactly 2 reads are issued (addresses 0,1); out_data holds row 0 stable.
  - After release, rows 0–7 arrive in order with no loss or duplication.
- Random out_ready (50%), cmd_len=256 → 256 rows in order; occ + inflight never exceeds 2; out_last exactly once.
- Zero-length command, cmd_len=0 → accepted, rd_en_out stays 0, no out_valid, cmd_ready remains 1.
- Reset mid-drain: rstn=0 for 1 cycle after the 3rd read.
  - Next cycle: out_valid=0, busy=0, cmd_ready=1.
  - A new command (addr=10, len=2) drains rows 10,11 only.

Source files
------------

// File: rtl/accum_rd_ctrl_if.sv
// Bundles the drain command, accumulator bank read port and output row stream
// of the accumulator read-side controller.
interface accum_rd_ctrl_if #(
    parameter int SYS_COL    = 16,
    parameter int ACCUM_ROW  = 256,
    parameter int DATA_WIDTH = 32
);
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [ADDR_WIDTH-1:0]         cmd_addr;
    logic [ADDR_WIDTH:0]           cmd_len;

    logic [SYS_COL-1:0]            rd_en_out;
    logic [ADDR_WIDTH-1:0]         rd_addr_out;
    logic [SYS_COL*DATA_WIDTH-1:0] rd_data_in;

    logic                          out_valid;
    logic                          out_ready;
    logic [SYS_COL*DATA_WIDTH-1:0] out_data;
    logic                          out_last;

    // master is the surrounding environment, slave is the controller itself
    modport master (
        output cmd_valid, cmd_addr, cmd_len, rd_data_in, out_ready,
        input  cmd_ready, rd_en_out, rd_addr_out, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, rd_data_in, out_ready,
        output cmd_ready, rd_en_out, rd_addr_out, out_valid, out_data, out_last
    );
endinterface

// File: rtl/accum_rd_ctrl.sv
// Accumulator SRAM read-side controller: drains a run of rows from all banks in
// lockstep into a 2-entry buffer feeding a valid/ready output stream.
module accum_rd_ctrl #(
    parameter int SYS_COL    = 16,
    parameter int ACCUM_ROW  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rstn,
    accum_rd_ctrl_if.slave bus,
    output logic           busy
);
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);
    localparam int ROW_WIDTH  = SYS_COL * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt, last_addr;
    logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
    logic                  inflight, inflight_last;
    logic [ROW_WIDTH-1:0]  buf_data [2];
    logic                  buf_last [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            occ;
    logic                  issue, pop, push, last_issue;

    assign pop        = (occ != 2'd0) && bus.out_ready;
    assign push       = inflight;
    assign last_issue = (remaining == (ADDR_WIDTH+1)'(1));

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        issue         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                    addr_nxt      = bus.cmd_addr;
                    remaining_nxt = bus.cmd_len;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // occ + inflight - pop < 2, rearranged to stay unsigned
                if (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop})) begin
                    issue         = 1'b1;
                    addr_nxt      = addr + ADDR_WIDTH'(1);
                    remaining_nxt = remaining - (ADDR_WIDTH+1)'(1);
                    if (last_issue) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && buf_last[rd_ptr]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            last_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            occ           <= 2'd0;
            buf_last[0]   <= 1'b0;
            buf_last[1]   <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            remaining     <= remaining_nxt;
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            if (issue) begin
                last_addr <= addr;
            end
            if (push) begin
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Row storage carries no reset; validity is tracked entirely by occ/pointers.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            buf_data[wr_ptr] <= bus.rd_data_in;
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rd_en_out   = {SYS_COL{issue}};
    assign bus.rd_addr_out = issue ? addr : last_addr;
    assign bus.out_valid   = (occ != 2'd0);
    assign bus.out_data    = buf_data[rd_ptr];
    assign bus.out_last    = (occ != 2'd0) && buf_last[rd_ptr];
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_accum_rd_ctrl.sv
// Randomized bench for accum_rd_ctrl: a bank memory model plus a row-queue
// reference of the expected read addresses and output rows.
module tb_accum_rd_ctrl;
    localparam int SYS_COL    = 16;
    localparam int ACCUM_ROW  = 256;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);
    localparam int ROW_W      = SYS_COL * DATA_WIDTH;

    typedef struct {
        int row;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    accum_rd_ctrl_if #(.SYS_COL(SYS_COL), .ACCUM_ROW(ACCUM_ROW), .DATA_WIDTH(DATA_WIDTH)) bus();

    accum_rd_ctrl #(.SYS_COL(SYS_COL), .ACCUM_ROW(ACCUM_ROW), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    exp_t             exp_out[$];
    int               exp_rd[$];
    bit               model_busy;
    int               last_rd_addr;
    int               issued, popped, last_seen;
    bit               cmd_accepted;
    bit               pend_valid;
    int               pend_addr;
    bit               prev_stall;
    logic [ROW_W-1:0] prev_data;
    logic             prev_last;
    logic             s_rd_en, s_out_valid, s_out_last, s_busy, s_cmd_ready;
    int               checks, failures;
    int               seed;

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ROW_W-1:0] rowData(input int row);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < SYS_COL; c++) begin
            r[c*DATA_WIDTH +: DATA_WIDTH] =
                DATA_WIDTH'((row << 24) | (c << 16) | ((row * 40503 ^ c * 977 ^ seed) & 32'hffff));
        end
        return r;
    endfunction

    // Sampled mid-cycle: compares the DUT against the row queues, then advances them.
    task automatic monitor();
        bit accept;
        int a, len;
        s_rd_en     = bus.rd_en_out[0];
        s_out_valid = bus.out_valid;
        s_out_last  = bus.out_last;
        s_busy      = busy;
        s_cmd_ready = bus.cmd_ready;
        pend_valid  = bus.rd_en_out[0];
        pend_addr   = int'(bus.rd_addr_out);
        cmd_accepted = 1'b0;
        if (!rstn) begin
            exp_out.delete();
            exp_rd.delete();
            model_busy   = 1'b0;
            last_rd_addr = 0;
            issued       = 0;
            popped       = 0;
            prev_stall   = 1'b0;
            return;
        end
        accept = bus.cmd_valid && !model_busy;
        checkOutput("cmd_ready", bus.cmd_ready, !model_busy);
        checkOutput("busy", busy, model_busy);
        checkOutput("rd_en_uniform", (bus.rd_en_out == '0) || (bus.rd_en_out == '1), 1);
        if (bus.rd_en_out[0]) begin
            if (exp_rd.size() == 0) begin
                checkOutput("spurious_read", 1, 0);
            end else begin
                a = exp_rd.pop_front();
                checkOutput("rd_addr", bus.rd_addr_out, a);
                last_rd_addr = a;
            end
            issued++;
        end else if (!model_busy) begin
            checkOutput("rd_addr_idle", bus.rd_addr_out, last_rd_addr);
        end
        if (prev_stall) begin
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_data", bus.out_data, prev_data);
            checkOutput("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_valid) begin
            if (exp_out.size() == 0) begin
                checkOutput("spurious_out", 1, 0);
            end else begin
                checkOutput("out_data", bus.out_data, rowData(exp_out[0].row));
                checkOutput("out_last", bus.out_last, exp_out[0].last);
                if (bus.out_ready) begin
                    if (exp_out[0].last) begin
                        model_busy = 1'b0;
                        last_seen++;
                    end
                    void'(exp_out.pop_front());
                    popped++;
                end
            end
        end
        checkOutput("outstanding", (issued - popped) <= 2, 1);
        if (accept) begin
            cmd_accepted = 1'b1;
            issued = 0;
            popped = 0;
            len = int'(bus.cmd_len);
            for (int i = 0; i < len; i++) begin
                exp_rd.push_back((int'(bus.cmd_addr) + i) % ACCUM_ROW);
                exp_out.push_back('{row: (int'(bus.cmd_addr) + i) % ACCUM_ROW, last: (i == len - 1)});
            end
            if (len > 0) model_busy = 1'b1;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pend_valid) bus.rd_data_in = rowData(pend_addr);
        else            bus.rd_data_in = {SYS_COL{$urandom}};
    endtask

    task automatic applyStimulus(input int addr, input int len);
        int n;
        n = 0;
        bus.cmd_addr  = ADDR_WIDTH'(addr);
        bus.cmd_len   = (ADDR_WIDTH+1)'(len);
        bus.cmd_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!cmd_accepted && n < 64);
        bus.cmd_valid = 1'b0;
        checkOutput("cmd_accept", cmd_accepted, 1);
    endtask

    task automatic waitIdle(input bit rand_ready, input int bound);
        int n;
        n = 0;
        while ((model_busy || exp_out.size() != 0) && n < bound) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checkOutput("drain_done", model_busy || (exp_out.size() != 0), 0);
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        seed = int'($urandom);
        checks = 0; failures = 0; last_seen = 0;
        model_busy = 1'b0; last_rd_addr = 0; issued = 0; popped = 0;
        prev_stall = 1'b0; pend_valid = 1'b0; pend_addr = 0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.out_ready = 1'b0; bus.rd_data_in = '0;

        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        checkOutput("rst_out_valid", s_out_valid, 0);
        checkOutput("rst_out_last", s_out_last, 0);
        checkOutput("rst_busy", s_busy, 0);
        checkOutput("rst_cmd_ready", s_cmd_ready, 1);
        checkOutput("rst_rd_en", s_rd_en, 0);

        $display("[TB] basic drain");
        bus.out_ready = 1'b1;
        applyStimulus(5, 4);
        for (int k = 1; k <= 7; k++) begin
            bus.cmd_valid = (k == 2);
            bus.cmd_addr  = ADDR_WIDTH'(99);
            bus.cmd_len   = (ADDR_WIDTH+1)'(3);
            tick();
            checkOutput("t_rd_en", s_rd_en, (k >= 1) && (k <= 4));
            checkOutput("t_out_valid", s_out_valid, (k >= 3) && (k <= 6));
            checkOutput("t_busy", s_busy, k < 7);
            checkOutput("t_cmd_ready", s_cmd_ready, k >= 7);
        end
        bus.cmd_valid = 1'b0;

        $display("[TB] wrap-around");
        applyStimulus(254, 4);
        waitIdle(1'b0, 50);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(0, 8);
        for (int k = 1; k <= 10; k++) tick();
        checkOutput("bp_reads", issued, 2);
        bus.out_ready = 1'b1;
        waitIdle(1'b0, 100);

        $display("[TB] random ready full bank");
        last_seen = 0;
        applyStimulus(int'($urandom_range(0, ACCUM_ROW - 1)), ACCUM_ROW);
        waitIdle(1'b1, 3000);
        checkOutput("last_once", last_seen, 1);

        $display("[TB] zero length");
        applyStimulus(7, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("z_rd_en", s_rd_en, 0);
            checkOutput("z_out_valid", s_out_valid, 0);
            checkOutput("z_cmd_ready", s_cmd_ready, 1);
        end

        $display("[TB] reset mid-drain");
        bus.out_ready = 1'b1;
        applyStimulus(20, 6);
        n = 0;
        while (issued < 3 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("mr_third_read", issued >= 3, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("mr_out_valid", s_out_valid, 0);
        checkOutput("mr_busy", s_busy, 0);
        checkOutput("mr_cmd_ready", s_cmd_ready, 1);
        applyStimulus(10, 2);
        waitIdle(1'b0, 50);

        $display("[TB] random commands");
        repeat (6) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            applyStimulus(int'($urandom_range(0, ACCUM_ROW - 1)), int'($urandom_range(0, 20)));
            waitIdle(1'b1, 500);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
